atm_txn_monitor: RTL and testbench
==================================

Name: atm_txn_monitor

Overview:
- Downstream of the ATM controller. Watches its result outputs (success, nobalance, incorrectpassword) and the operation, amount and balance in effect at each result.
- Logs every completed transaction into a circular buffer that a host or service port can read.
- Counts consecutive wrong-PIN events and asserts card_retain once the limit is reached.
- Pure observer: it never drives the ATM.

Parameters:
- DEPTH, 8, log entries; power of two, 2..64.
- MAX_TRIES, 3, consecutive incorrect-password events that trigger card_retain; 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- incard  in  1  card-present level from the ATM front end.
- operation  in  2  ATM operation code (00 deposit, 01 balance, 10 withdraw).
- amount  in  6  transaction amount presented to the ATM.
- balance  in  6  ATM balance output.
- success  in  1  ATM success level.
- nobalance  in  1  ATM insufficient-funds level.
- incorrectpassword  in  1  ATM wrong-PIN level.
- rd_en  in  1  read request, one entry per cycle.
- unlock  in  1  service pulse that clears card_retain and the try counter.
- rd_data  out  16  log entry.
- rd_valid  out  1  rd_data valid this cycle.
- empty  out  1  log empty.
- full  out  1  log full.
- count  out  clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky: an entry was overwritten.
- card_retain  out  1  sticky lockout flag.
- fail_cnt  out  4  current consecutive wrong-PIN count.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
  - overflow=0, card_retain=0, fail_cnt=0, rd_valid=0, rd_data=0.
  - Edge-detect history registers cleared.
  - Reset mid-read discards the pending rd_valid.
- Event detection:
  - Each status input is registered once; an event is a 0->1 transition versus the previous cycle.
  - The first cycle after reset cannot produce an event from a level already high before reset: the history registers load the current input values on that cycle.
- Simultaneous rising edges in one cycle produce exactly one event. Priority: incorrectpassword > nobalance > success.
- Entry format, captured from the same-cycle input values:
  - [15:14] status: 00 success, 01 nobalance, 10 badpin.
  - [13:12] operation.
  - [11:6] amount.
  - [5:0] balance.
  - For badpin entries, operation and amount are forced to 0.
- Write timing: an event in cycle N writes the entry at the edge ending cycle N, so count increments one cycle after the rising input.
- Read timing: rd_en=1 with empty=0 in cycle N gives rd_data and rd_valid=1 in cycle N+1, and rd_ptr advances. rd_en while empty is ignored: rd_valid=0 and no state change.
- Full with an event and no read: the oldest entry is overwritten, rd_ptr advances, count stays DEPTH, overflow is set. overflow clears only on reset.
- Full with an event and a read in the same cycle: the read returns the oldest entry and the write fills the freed slot. count is unchanged and overflow is not set.
- Not full with an event and a read in the same cycle: count is unchanged.
- Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- Lockout counter:
  - badpin event: fail_cnt increments, saturating at 15.
  - success or nobalance event: fail_cnt clears to 0, unless card_retain=1.
  - incard falling edge: fail_cnt clears, unless card_retain=1.
  - card_retain is set in the cycle after fail_cnt reaches MAX_TRIES, i.e. registered from fail_cnt>=MAX_TRIES.
  - While card_retain=1, fail_cnt holds its value; events are still logged.
- unlock pulse: clears card_retain and fail_cnt next edge. If a badpin event arrives in the same cycle as unlock, unlock wins and the event is still logged.

Decomposition:
- Package atm_pkg:
  - status codes ST_SUCCESS, ST_NOBAL, ST_BADPIN.
  - operation codes OP_DEPOSIT, OP_BALANCE, OP_WITHDRAW.
  - log entry struct/width constant LOG_W=16.
  - field offset constants.
- One sub-module, atm_log_ring: a parameterised circular buffer with overwrite-oldest policy, count, full/empty and overflow.
- Event detect, priority and lockout logic stay in the top module.

Test Plan:
- Reset, then raise success with operation=00, amount=34, balance=34 -> after one edge count=1. rd_en -> next cycle rd_valid=1, rd_data=16'h08A2, empty=1.
- incorrectpassword pulsed three times, each separated by a low cycle -> fail_cnt 1,2,3; card_retain=1 one cycle after the third edge. unlock -> card_retain=0, fail_cnt=0. Three entries with status 10.
- Two badpin events, then a success event -> fail_cnt 2 then 0, card_retain stays 0.
- Ten success events with DEPTH=8 and no reads -> count=8, full=1, overflow=1. The eight reads return events 3..10 in order; the final read leaves empty=1.
- With full=1, an event and rd_en in the same cycle -> overflow unchanged (0 after fresh reset), count=8, read returns the oldest entry.
- success and incorrectpassword rise in the same cycle -> one entry, status 10, fail_cnt=1. Holding the levels high produces no further entries.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared status/operation codes and log-entry layout for the ATM transaction monitor.
package atm_pkg;

   localparam int LOG_W   = 16;
   localparam int ST_W    = 2;
   localparam int OP_W    = 2;
   localparam int AMT_W   = 6;
   localparam int BAL_W   = 6;
   localparam int ST_LSB  = 14;
   localparam int OP_LSB  = 12;
   localparam int AMT_LSB = 6;
   localparam int BAL_LSB = 0;

   typedef enum logic [1:0] {
      ST_SUCCESS = 2'b00,
      ST_NOBAL   = 2'b01,
      ST_BADPIN  = 2'b10
   } status_e;

   typedef enum logic [1:0] {
      OP_DEPOSIT  = 2'b00,
      OP_BALANCE  = 2'b01,
      OP_WITHDRAW = 2'b10
   } op_e;

   // Wrong-PIN entries carry no meaningful operation/amount, so those fields are zeroed.
   function automatic logic [LOG_W-1:0] make_entry(input status_e st,
                                                   input logic [OP_W-1:0] op,
                                                   input logic [AMT_W-1:0] amt,
                                                   input logic [BAL_W-1:0] bal);
      logic [LOG_W-1:0] e;
      e = {LOG_W{1'b0}};
      e[ST_LSB +: ST_W] = st;
      if (st == ST_BADPIN) begin
         e[OP_LSB +: OP_W]   = OP_DEPOSIT;
         e[AMT_LSB +: AMT_W] = {AMT_W{1'b0}};
      end else begin
         e[OP_LSB +: OP_W]   = op;
         e[AMT_LSB +: AMT_W] = amt;
      end
      e[BAL_LSB +: BAL_W] = bal;
      return e;
   endfunction

endpackage

// File: rtl/atm_log_ring.sv
// Circular log buffer: overwrites the oldest entry when full, one read per cycle.
module atm_log_ring #(
   parameter int DEPTH = 8,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [W-1:0]  rd_data_r;
   logic          rd_valid_r;
   logic          overflow_r;
   logic          empty_s;
   logic          full_s;
   logic          do_rd_s;

   assign empty_s = (count_r == {CW{1'b0}});
   assign full_s  = (count_r == CW'(DEPTH));
   assign do_rd_s = rd_en & ~empty_s;

   // Storage array; a write into a full slot being read returns the old value.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers, occupancy, sticky overflow and read port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         rd_data_r  <= {W{1'b0}};
         rd_valid_r <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         rd_valid_r <= do_rd_s;
         if (do_rd_s) begin
            rd_data_r <= mem_r[rd_ptr_r];
         end
         if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         end
         // A write into a full buffer without a read drops the oldest entry.
         if (do_rd_s || (wr_en && full_s)) begin
            rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         end
         if (wr_en && full_s && !do_rd_s) begin
            overflow_r <= 1'b1;
         end
         if (wr_en && !do_rd_s && !full_s) begin
            count_r <= count_r + CW'(1'b1);
         end else if (!wr_en && do_rd_s) begin
            count_r <= count_r - CW'(1'b1);
         end
      end
   end

   assign rd_data  = rd_data_r;
   assign rd_valid = rd_valid_r;
   assign empty    = empty_s;
   assign full     = full_s;
   assign count    = count_r;
   assign overflow = overflow_r;

endmodule

// File: rtl/atm_txn_monitor.sv
// Passive ATM result monitor: edge-detects results, logs them, and tracks wrong-PIN lockout.
module atm_txn_monitor
   import atm_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int MAX_TRIES = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     incard,
   input  logic [1:0]               operation,
   input  logic [5:0]               amount,
   input  logic [5:0]               balance,
   input  logic                     success,
   input  logic                     nobalance,
   input  logic                     incorrectpassword,
   input  logic                     rd_en,
   input  logic                     unlock,
   output logic [15:0]              rd_data,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     card_retain,
   output logic [3:0]               fail_cnt
);

   logic             armed_r;
   logic             hist_suc_r;
   logic             hist_nob_r;
   logic             hist_bad_r;
   logic             hist_card_r;
   logic             rise_suc_s;
   logic             rise_nob_s;
   logic             rise_bad_s;
   logic             card_fall_s;
   logic             ev_s;
   status_e          st_s;
   logic [LOG_W-1:0] entry_s;
   logic [3:0]       fail_cnt_r;
   logic             card_retain_r;

   // armed_r is low for the first cycle after reset so pre-reset levels never look like edges.
   assign rise_suc_s  = armed_r & success & ~hist_suc_r;
   assign rise_nob_s  = armed_r & nobalance & ~hist_nob_r;
   assign rise_bad_s  = armed_r & incorrectpassword & ~hist_bad_r;
   assign card_fall_s = armed_r & ~incard & hist_card_r;
   assign ev_s        = rise_suc_s | rise_nob_s | rise_bad_s;

   // Coincident edges collapse to one event; wrong PIN dominates.
   always_comb begin
      st_s = ST_SUCCESS;
      if (rise_bad_s) begin
         st_s = ST_BADPIN;
      end else if (rise_nob_s) begin
         st_s = ST_NOBAL;
      end else begin
         st_s = ST_SUCCESS;
      end
   end

   assign entry_s = make_entry(st_s, operation, amount, balance);

   // Previous-cycle copies of the status levels for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         armed_r     <= 1'b0;
         hist_suc_r  <= 1'b0;
         hist_nob_r  <= 1'b0;
         hist_bad_r  <= 1'b0;
         hist_card_r <= 1'b0;
      end else begin
         armed_r     <= 1'b1;
         hist_suc_r  <= success;
         hist_nob_r  <= nobalance;
         hist_bad_r  <= incorrectpassword;
         hist_card_r <= incard;
      end
   end

   // Consecutive wrong-PIN counter and sticky card retention; unlock overrides everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fail_cnt_r    <= 4'd0;
         card_retain_r <= 1'b0;
      end else begin
         if (unlock) begin
            fail_cnt_r <= 4'd0;
         end else if (card_retain_r) begin
            fail_cnt_r <= fail_cnt_r;
         end else if (rise_bad_s) begin
            fail_cnt_r <= (fail_cnt_r == 4'hF) ? 4'hF : fail_cnt_r + 4'd1;
         end else if (rise_suc_s || rise_nob_s || card_fall_s) begin
            fail_cnt_r <= 4'd0;
         end
         if (unlock) begin
            card_retain_r <= 1'b0;
         end else if (fail_cnt_r >= 4'(MAX_TRIES)) begin
            card_retain_r <= 1'b1;
         end
      end
   end

   atm_log_ring #(
      .DEPTH (DEPTH),
      .W     (LOG_W)
   ) u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (ev_s),
      .wr_data  (entry_s),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

   assign fail_cnt    = fail_cnt_r;
   assign card_retain = card_retain_r;

endmodule

// File: tb/tb_atm_txn_monitor.sv
// Self-checking bench for atm_txn_monitor: directed scenarios plus random traffic vs a queue model.
module tb_atm_txn_monitor;

   localparam int DEPTH     = 8;
   localparam int MAX_TRIES = 3;
   localparam int CW        = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          incard;
   logic [1:0]    operation;
   logic [5:0]    amount;
   logic [5:0]    balance;
   logic          success;
   logic          nobalance;
   logic          incorrectpassword;
   logic          rd_en;
   logic          unlock;
   logic [15:0]   rd_data;
   logic          rd_valid;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic          overflow;
   logic          card_retain;
   logic [3:0]    fail_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: the log is simply a bounded queue of entries.
   logic [15:0] m_q[$];
   bit          m_ovf;
   bit          m_retain;
   bit          m_armed;
   bit          m_valid;
   int          m_fail;
   logic [15:0] m_data;
   bit          p_suc, p_nob, p_bad, p_card;

   always #5 clk = ~clk;

   atm_txn_monitor #(.DEPTH(DEPTH), .MAX_TRIES(MAX_TRIES)) dut (
      .clk(clk), .rst_n(rst_n), .incard(incard), .operation(operation),
      .amount(amount), .balance(balance), .success(success), .nobalance(nobalance),
      .incorrectpassword(incorrectpassword), .rd_en(rd_en), .unlock(unlock),
      .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
      .count(count), .overflow(overflow), .card_retain(card_retain), .fail_cnt(fail_cnt)
   );

   // Advance the model by one cycle from the current inputs, then clock the DUT.
   task automatic tick();
      bit          e_suc, e_nob, e_bad, c_fall;
      logic [15:0] ent;
      logic [15:0] drop;
      int          old_fail;
      if (!rst_n) begin
         m_q.delete();
         m_ovf = 0; m_retain = 0; m_fail = 0; m_valid = 0; m_data = 16'h0000; m_armed = 0;
         p_suc = 0; p_nob = 0; p_bad = 0; p_card = 0;
      end else begin
         e_bad  = m_armed && incorrectpassword && !p_bad;
         e_nob  = m_armed && nobalance && !p_nob;
         e_suc  = m_armed && success && !p_suc;
         c_fall = m_armed && !incard && p_card;
         old_fail = m_fail;
         m_valid = 0;
         if (rd_en && m_q.size() > 0) begin
            m_data  = m_q.pop_front();
            m_valid = 1;
         end
         if (e_bad || e_nob || e_suc) begin
            if (e_bad)      ent = {2'b10, 2'b00, 6'd0, balance};
            else if (e_nob) ent = {2'b01, operation, amount, balance};
            else            ent = {2'b00, operation, amount, balance};
            if (m_q.size() == DEPTH) begin
               drop  = m_q.pop_front();
               m_ovf = 1;
            end
            m_q.push_back(ent);
         end
         if (unlock) m_fail = 0;
         else if (!m_retain) begin
            if (e_bad) m_fail = (m_fail < 15) ? m_fail + 1 : 15;
            else if (e_nob || e_suc || c_fall) m_fail = 0;
         end
         if (unlock) m_retain = 0;
         else if (old_fail >= MAX_TRIES) m_retain = 1;
         p_suc = success; p_nob = nobalance; p_bad = incorrectpassword; p_card = incard;
         m_armed = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      incard = 1'b1; operation = 2'b00; amount = 6'd0; balance = 6'd0;
      success = 1'b0; nobalance = 1'b0; incorrectpassword = 1'b0;
      rd_en = 1'b0; unlock = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic pulse_bad(input logic [5:0] bal);
      balance = bal; incorrectpassword = 1'b1;
      tick();
      incorrectpassword = 1'b0;
      tick();
   endtask

   task automatic pulse_suc(input logic [5:0] amt);
      operation = 2'b00; amount = amt; balance = amt; success = 1'b1;
      tick();
      success = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      success = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
         n_errors++; $display("FAIL reset_occ: count=%0d empty=%0b full=%0b expected 0/1/0", count, empty, full); end
      n_checks++; if (overflow !== 1'b0 || card_retain !== 1'b0 || fail_cnt !== 4'd0) begin
         n_errors++; $display("FAIL reset_flags: ovf=%0b retain=%0b fail=%0d expected 0/0/0", overflow, card_retain, fail_cnt); end
      n_checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
         n_errors++; $display("FAIL reset_rd: valid=%0b data=%h expected 0/0000", rd_valid, rd_data); end
      rst_n = 1'b1;
      tick();
      tick();
      n_checks++; if (count !== 4'd0) begin
         n_errors++; $display("FAIL reset_no_event: count=%0d expected 0", count); end
      success = 1'b0;
      tick();
      pulse_suc(6'd7);
      rd_en = 1'b1; rst_n = 1'b0;
      tick();
      rd_en = 1'b0; rst_n = 1'b1;
      n_checks++; if (rd_valid !== 1'b0 || count !== 4'd0) begin
         n_errors++; $display("FAIL reset_mid_read: valid=%0b count=%0d expected 0/0", rd_valid, count); end
      tick();
   endtask

   task automatic test_basic_log();
      do_reset();
      operation = 2'b00; amount = 6'd34; balance = 6'd34; success = 1'b1;
      tick();
      n_checks++; if (count !== 4'd1) begin
         n_errors++; $display("FAIL basic_count: count=%0d expected 1", count); end
      success = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h08A2 || empty !== 1'b1) begin
         n_errors++; $display("FAIL basic_read: valid=%0b data=%h empty=%0b expected 1/08a2/1", rd_valid, rd_data, empty); end
   endtask

   task automatic test_lockout();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         balance = 6'(10 + i); incorrectpassword = 1'b1;
         tick();
         n_checks++; if (fail_cnt !== 4'(i + 1) || card_retain !== 1'b0) begin
            n_errors++; $display("FAIL lock_cnt%0d: fail=%0d retain=%0b expected %0d/0", i, fail_cnt, card_retain, i + 1); end
         incorrectpassword = 1'b0;
         tick();
         n_checks++; if (card_retain !== (i == 2)) begin
            n_errors++; $display("FAIL lock_retain%0d: retain=%0b expected %0b", i, card_retain, (i == 2)); end
      end
      unlock = 1'b1;
      tick();
      unlock = 1'b0;
      n_checks++; if (card_retain !== 1'b0 || fail_cnt !== 4'd0) begin
         n_errors++; $display("FAIL lock_unlock: retain=%0b fail=%0d expected 0/0", card_retain, fail_cnt); end
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (rd_valid !== 1'b1 || rd_data !== {2'b10, 8'h00, 6'(10 + i)} || rd_data !== m_data) begin
            n_errors++; $display("FAIL lock_entry%0d: data=%h expected %h", i, rd_data, {2'b10, 8'h00, 6'(10 + i)}); end
      end
      rd_en = 1'b0;
      tick();
   endtask

   task automatic test_badpin_clear();
      do_reset();
      pulse_bad(6'd1);
      pulse_bad(6'd2);
      n_checks++; if (fail_cnt !== 4'd2) begin
         n_errors++; $display("FAIL clear_two: fail=%0d expected 2", fail_cnt); end
      pulse_suc(6'd3);
      n_checks++; if (fail_cnt !== 4'd0 || card_retain !== 1'b0) begin
         n_errors++; $display("FAIL clear_succ: fail=%0d retain=%0b expected 0/0", fail_cnt, card_retain); end
      pulse_bad(6'd4);
      incard = 1'b0;
      tick();
      incard = 1'b1;
      n_checks++; if (fail_cnt !== 4'd0) begin
         n_errors++; $display("FAIL clear_incard: fail=%0d expected 0", fail_cnt); end
   endtask

   task automatic test_unlock_race();
      do_reset();
      for (int i = 0; i < 3; i++) pulse_bad(6'd5);
      n_checks++; if (card_retain !== 1'b1) begin
         n_errors++; $display("FAIL race_pre: retain=%0b expected 1", card_retain); end
      unlock = 1'b1; incorrectpassword = 1'b1;
      tick();
      unlock = 1'b0; incorrectpassword = 1'b0;
      n_checks++; if (card_retain !== 1'b0 || fail_cnt !== 4'd0 || count !== 4'd4) begin
         n_errors++; $display("FAIL race_unlock: retain=%0b fail=%0d count=%0d expected 0/0/4", card_retain, fail_cnt, count); end
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 10; i++) pulse_suc(6'(i));
      n_checks++; if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1) begin
         n_errors++; $display("FAIL ovf_state: count=%0d full=%0b ovf=%0b expected 8/1/1", count, full, overflow); end
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++; if (rd_valid !== 1'b1 || rd_data[11:6] !== 6'(i + 3) || rd_data !== m_data) begin
            n_errors++; $display("FAIL ovf_read%0d: valid=%0b amount=%0d expected 1/%0d", i, rd_valid, rd_data[11:6], i + 3); end
      end
      rd_en = 1'b0;
      n_checks++; if (empty !== 1'b1) begin
         n_errors++; $display("FAIL ovf_empty: empty=%0b expected 1", empty); end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_checks++; if (rd_valid !== 1'b0 || count !== 4'd0) begin
         n_errors++; $display("FAIL empty_read: valid=%0b count=%0d expected 0/0", rd_valid, count); end
   endtask

   task automatic test_full_rw();
      do_reset();
      for (int i = 1; i <= 8; i++) pulse_suc(6'(i));
      operation = 2'b10; amount = 6'd63; balance = 6'd0; success = 1'b1; rd_en = 1'b1;
      tick();
      success = 1'b0; rd_en = 1'b0;
      n_checks++; if (overflow !== 1'b0 || count !== 4'd8 || rd_valid !== 1'b1 || rd_data[11:6] !== 6'd1) begin
         n_errors++; $display("FAIL full_rw: ovf=%0b count=%0d valid=%0b amount=%0d expected 0/8/1/1", overflow, count, rd_valid, rd_data[11:6]); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      operation = 2'b10; amount = 6'd5; balance = 6'd9; success = 1'b1; incorrectpassword = 1'b1;
      tick();
      n_checks++; if (count !== 4'd1 || fail_cnt !== 4'd1) begin
         n_errors++; $display("FAIL simul_one: count=%0d fail=%0d expected 1/1", count, fail_cnt); end
      tick(); tick(); tick();
      n_checks++; if (count !== 4'd1) begin
         n_errors++; $display("FAIL simul_hold: count=%0d expected 1", count); end
      success = 1'b0; incorrectpassword = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_checks++; if (rd_data !== 16'h8009) begin
         n_errors++; $display("FAIL simul_entry: data=%h expected 8009", rd_data); end
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         incard            = ($urandom_range(0, 15) != 0);
         operation         = 2'($urandom_range(0, 2));
         amount            = 6'($urandom_range(0, 63));
         balance           = 6'($urandom_range(0, 63));
         success           = ($urandom_range(0, 3) == 0);
         nobalance         = ($urandom_range(0, 5) == 0);
         incorrectpassword = ($urandom_range(0, 3) == 0);
         rd_en             = ($urandom_range(0, 2) == 0);
         unlock            = ($urandom_range(0, 31) == 0);
         tick();
         n_checks++; if (count !== CW'(m_q.size()) || overflow !== m_ovf) begin
            n_errors++; $display("FAIL rnd_occ cyc %0d: count=%0d ovf=%0b expected %0d/%0b", cyc, count, overflow, m_q.size(), m_ovf); end
         n_checks++; if (fail_cnt !== 4'(m_fail) || card_retain !== m_retain) begin
            n_errors++; $display("FAIL rnd_lock cyc %0d: fail=%0d retain=%0b expected %0d/%0b", cyc, fail_cnt, card_retain, m_fail, m_retain); end
         n_checks++; if (rd_valid !== m_valid || (m_valid && rd_data !== m_data)) begin
            n_errors++; $display("FAIL rnd_read cyc %0d: valid=%0b data=%h expected %0b/%h", cyc, rd_valid, rd_data, m_valid, m_data); end
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_basic_log();
      test_lockout();
      test_badpin_clear();
      test_unlock_race();
      test_overflow();
      test_full_rw();
      test_simultaneous();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
